// File: rtl/spi_mem_slave.sv
// SPI slave in front of a 2**ADDR_WIDTH-word register memory, oversampled on clk, all four SPI modes.
// Define SPI_BURST_EN to keep streaming words at incrementing addresses until cs rises.
module spi_mem_slave #(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk_pin,
  input  logic cs_pin,
  input  logic mosi_pin,
  output logic miso_pin,
  output logic miso_oe,
  output logic busy
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam int unsigned MAX_BITS = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CNT_W    = $clog2(MAX_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_RW, S_READ, S_WRITE, S_DONE
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;

  logic [ADDR_WIDTH-1:0]  addr, wr_addr;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0]  rx_shift, tx_shift;
  logic                   wr_en;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  // Synchronisers; cs resets to "asserted" so a frame only starts after a real rise then fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= CPOL;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_pin};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_pin};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_pin};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise, addr_last, data_last;

  assign sclk_rise   = sclk_s & ~sclk_d;
  assign sclk_fall   = ~sclk_s & sclk_d;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = ~cs_s & (CPHA ? trail_edge : lead_edge);
  assign shift_edge  = ~cs_s & (CPHA ? lead_edge : trail_edge);
  assign cs_fall     = cs_d & ~cs_s;
  assign cs_rise     = ~cs_d & cs_s;
  assign addr_last   = (bit_cnt == CNT_W'(ADDR_WIDTH - 1));
  assign data_last   = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

`ifdef SPI_BURST_EN
  logic [ADDR_WIDTH-1:0] addr_inc;
  assign addr_inc = addr + ADDR_WIDTH'(1);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (cs_fall) state_next = S_ADDR;
      S_ADDR:  if (sample_edge && addr_last) state_next = S_RW;
      S_RW:    if (sample_edge) state_next = mosi_s ? S_READ : S_WRITE;
      S_READ, S_WRITE: begin
`ifdef SPI_BURST_EN
        state_next = state;
`else
        if (sample_edge && data_last) state_next = S_DONE;
`endif
      end
      S_DONE:  state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
    if (cs_rise) state_next = S_IDLE;
  end

  // Frame datapath: address/data shifters, MISO driver and write request.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr     <= '0;
      wr_addr  <= '0;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      wr_en    <= 1'b0;
      miso_pin <= 1'b0;
      miso_oe  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      busy  <= (state_next != S_IDLE) && (state_next != S_DONE);
      if (cs_rise || state == S_IDLE) begin
        bit_cnt  <= '0;
        miso_pin <= 1'b0;
        miso_oe  <= 1'b0;
      end else begin
        case (state)
          S_ADDR: if (sample_edge) begin
            addr    <= {addr[ADDR_WIDTH-2:0], mosi_s};
            bit_cnt <= addr_last ? '0 : bit_cnt + CNT_W'(1);
          end
          S_RW: if (sample_edge && mosi_s) tx_shift <= mem[addr];
          S_READ: begin
            if (shift_edge) begin
              miso_pin <= tx_shift[DATA_WIDTH-1];
              miso_oe  <= 1'b1;
              tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
            if (sample_edge) begin
              bit_cnt <= data_last ? '0 : bit_cnt + CNT_W'(1);
              if (data_last) begin
                miso_pin <= 1'b0;
                miso_oe  <= 1'b0;
`ifdef SPI_BURST_EN
                addr     <= addr_inc;
                tx_shift <= mem[addr_inc];
`endif
              end
            end
          end
          S_WRITE: if (sample_edge) begin
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
            bit_cnt  <= data_last ? '0 : bit_cnt + CNT_W'(1);
            if (data_last) begin
              wr_en   <= 1'b1;
              wr_addr <= addr;
`ifdef SPI_BURST_EN
              addr    <= addr_inc;
`endif
            end
          end
          S_DONE: begin
            miso_pin <= 1'b0;
            miso_oe  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Commit lands one clk after the last data bit was sampled; reset blocks it.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wr_addr] <= rx_shift;
  end

endmodule

// File: tb/tb_spi_mem_slave.sv
// Bench for spi_mem_slave: one instance per SPI mode, a bit-level SPI master and a frame-level memory model.
// Honours SPI_BURST_EN the same way as the design.
module tb_spi_mem_slave;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sclk_v, cs_v, mosi_v;
  logic [3:0] miso_v, oe_v, busy_v;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] mem_m   [4][128];
  bit         known_m [4][128];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_mem_slave #(
      .ADDR_WIDTH(7), .DATA_WIDTH(8), .CPOL(g >= 2), .CPHA(g % 2 == 1), .SYNC_STAGES(2)
    ) u_dut (
      .clk(clk), .reset(reset), .sclk_pin(sclk_v[g]), .cs_pin(cs_v[g]), .mosi_pin(mosi_v[g]),
      .miso_pin(miso_v[g]), .miso_oe(oe_v[g]), .busy(busy_v[g])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_half();
    repeat (HALF) @(negedge clk);
  endtask

  // Master sample point for cycle i: record MISO and compare against the model.
  task automatic sample(input int m, input int i, input logic [6:0] a, input logic rw,
                        inout logic [63:0] rx);
    int w, j;
    bit stopped;
    logic [6:0] wa;
    rx[63-i] = miso_v[m];
    if (i == 3) check("busy_frame", busy_v[m], 1);
    if (i < 8 || !rw) begin
      check("oe_off", oe_v[m], 0);
    end else begin
      w = (i - 8) / 8;
      j = (i - 8) % 8;
      stopped = 1'b0;
`ifndef SPI_BURST_EN
      stopped = (w > 0);
`endif
      if (stopped) begin
        check("oe_after_word", oe_v[m], 0);
      end else begin
        check("oe_read", oe_v[m], 1);
        wa = 7'(a + 7'(w));
        if (known_m[m][wa]) check("miso_bit", miso_v[m], mem_m[m][wa][7-j]);
      end
    end
  endtask

  // One frame of n sclk cycles on mode m; bit for cycle i is bits[63-i].
  task automatic spi_frame(input int m, input logic [63:0] bits, input int n,
                           input bit raise_cs, output logic [63:0] rx);
    logic [6:0] a, wa;
    logic rw;
    int k;
    rx = '0;
    a  = bits[63:57];
    rw = bits[56];
    @(negedge clk);
    cs_v[m]   = 1'b0;
    mosi_v[m] = m[0] ? 1'b0 : bits[63];
    wait_half();
    for (int i = 0; i < n; i++) begin
      if (m[0] == 1'b0) begin
        sclk_v[m] = ~sclk_v[m];
        sample(m, i, a, rw, rx);
        wait_half();
        sclk_v[m] = ~sclk_v[m];
        if (i + 1 < n) mosi_v[m] = bits[63-(i+1)];
        wait_half();
      end else begin
        sclk_v[m] = ~sclk_v[m];
        mosi_v[m] = bits[63-i];
        wait_half();
        sclk_v[m] = ~sclk_v[m];
        sample(m, i, a, rw, rx);
        wait_half();
      end
    end
    k = (n >= 8) ? (n - 8) / 8 : 0;
`ifdef SPI_BURST_EN
    check("busy_end", busy_v[m], 1);
`else
    check("busy_end", busy_v[m], (k >= 1) ? 0 : 1);
    if (k > 1) k = 1;
`endif
    if (raise_cs) begin
      cs_v[m]   = 1'b1;
      mosi_v[m] = 1'b0;
      repeat (6) @(negedge clk);
      check("busy_idle", busy_v[m], 0);
      check("oe_idle", oe_v[m], 0);
      if (!rw) begin
        for (int w = 0; w < k; w++) begin
          wa = 7'(a + 7'(w));
          mem_m[m][wa]   = bits[55-8*w -: 8];
          known_m[m][wa] = 1'b1;
        end
      end
      repeat (4) @(negedge clk);
    end
  endtask

  // Whenever the output is not enabled it must be held low.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++)
      if (oe_v[g] == 1'b0) check("miso_quiet", miso_v[g], 0);
  end

  initial begin
    logic [63:0] rx, bits;
    logic [6:0]  addr;
    logic        rw;
    int          m, n, sel;

    foreach (known_m[i, j]) known_m[i][j] = 1'b0;
    reset  = 1'b1;
    sclk_v = 4'b1100;
    cs_v   = 4'hF;
    mosi_v = 4'h0;
    repeat (5) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      check("rst_busy", busy_v[g], 0);
      check("rst_oe", oe_v[g], 0);
      check("rst_miso", miso_v[g], 0);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Mode 0 write/read of 0x2A
    spi_frame(0, {7'h2A, 1'b0, 8'hA5, 48'h0}, 16, 1, rx);
    spi_frame(0, {7'h2A, 1'b1, 56'h0}, 16, 1, rx);
    check("m0_readback", rx[55:48], 8'hA5);

    // Modes 1..3
    for (int g = 1; g < 4; g++) begin
      spi_frame(g, {7'h2A, 1'b0, 8'h3C, 48'h0}, 16, 1, rx);
      spi_frame(g, {7'h2A, 1'b1, 56'h0}, 16, 1, rx);
      check("mode_readback", rx[55:48], 8'h3C);
    end

    // Partial word is discarded, next frame decodes cleanly
    spi_frame(0, {7'h10, 1'b0, 8'h5A, 48'h0}, 16, 1, rx);
    spi_frame(0, {7'h10, 1'b0, 8'hFF, 48'h0}, 12, 1, rx);
    spi_frame(0, {7'h10, 1'b1, 56'h0}, 16, 1, rx);
    check("partial_kept", rx[55:48], 8'h5A);
    spi_frame(0, {7'h11, 1'b0, 8'hC3, 48'h0}, 16, 1, rx);
    spi_frame(0, {7'h11, 1'b1, 56'h0}, 16, 1, rx);
    check("after_partial", rx[55:48], 8'hC3);

    // Reset mid-write
    spi_frame(0, {7'h20, 1'b0, 8'h99, 48'h0}, 10, 0, rx);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy_v[0], 0);
    check("midrst_oe", oe_v[0], 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_no_restart", busy_v[0], 0);
    cs_v[0]   = 1'b1;
    mosi_v[0] = 1'b0;
    repeat (10) @(negedge clk);
    spi_frame(0, {7'h20, 1'b0, 8'h66, 48'h0}, 16, 1, rx);
    spi_frame(0, {7'h20, 1'b1, 56'h0}, 16, 1, rx);
    check("after_reset", rx[55:48], 8'h66);

`ifdef SPI_BURST_EN
    spi_frame(0, {7'h7F, 1'b0, 8'h11, 8'h22, 40'h0}, 24, 1, rx);
    spi_frame(0, {7'h7F, 1'b1, 56'h0}, 24, 1, rx);
    check("burst_w0", rx[55:48], 8'h11);
    check("burst_w1", rx[47:40], 8'h22);
    spi_frame(0, {7'h00, 1'b1, 56'h0}, 16, 1, rx);
    check("burst_wrap", rx[55:48], 8'h22);
`else
    spi_frame(0, {7'h06, 1'b0, 8'h33, 48'h0}, 16, 1, rx);
    spi_frame(0, {7'h05, 1'b0, 8'h77, 8'h99, 40'h0}, 24, 1, rx);
    spi_frame(0, {7'h05, 1'b1, 56'h0}, 16, 1, rx);
    check("single_w0", rx[55:48], 8'h77);
    spi_frame(0, {7'h06, 1'b1, 56'h0}, 16, 1, rx);
    check("single_next", rx[55:48], 8'h33);
`endif

    // Randomised frames around the address wrap point
    for (int t = 0; t < 30; t++) begin
      m    = $urandom_range(0, 3);
      rw   = 1'($urandom_range(0, 1));
      addr = 7'(($urandom_range(0, 19) + 118) % 128);
      bits = {$urandom(), $urandom()};
      bits = {addr, rw, bits[55:0]};
      sel  = $urandom_range(0, 3);
      case (sel)
        0:       n = 16;
        1:       n = 24;
        2:       n = $urandom_range(1, 31);
        default: n = 8;
      endcase
      spi_frame(m, bits, n, 1, rx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
